// File: rtl/trace_fifo_serializer.sv
// Trace port: captures PC changes (and IO writes when built with TRACE_WRITES_EN)
// into a FIFO and shows each record on the test header as held 6-bit symbols.
module trace_fifo_serializer #(
   parameter int DEPTH       = 16,
   parameter int HOLD_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_run,
   input  logic [23:0] pc,
   input  logic        io_wr,
   input  logic [23:0] io_a,
   input  logic [31:0] io_di,
   input  logic [3:0]  io_be,
   output logic [7:0]  test,
   output logic        fifo_full,
   output logic [7:0]  drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(HOLD_CYCLES);
`ifdef TRACE_WRITES_EN
   localparam int EW = 67;
`else
   localparam int EW = 24;
`endif
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_HALF  = HW'(HOLD_CYCLES / 2);
   localparam logic [3:0]    K_LAST     = 4'd10;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [23:0]   pc_last_reg;
   logic          pend_pc_v_reg, pend_pc_v_next;
   logic [23:0]   pend_pc_reg, pend_pc_next;
   logic          pc_event, wr_event, pend_v_eff;
   logic [23:0]   pend_pc_eff;
   logic          enq, room, push, pop, shift;
   logic [EW-1:0] enq_data;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg, count_next;
   logic [7:0]    drop_cnt_reg;

   state_t        state_reg, state_next;
   logic [HW-1:0] hold_reg, hold_next;
   logic [3:0]    k_reg;
   logic [65:0]   sr_reg;

`ifdef TRACE_WRITES_EN
   logic          io_wr_last_reg;
`else
   logic          unused_io;
   assign unused_io = ^{io_wr, io_a, io_di, io_be};
`endif

   // A PC event bypasses the pending register so it can enqueue in its own
   // cycle; it only waits in pend_pc when a write event claims the slot.
   always_comb begin
      pc_event    = cpu_run && (pc[23:20] != 4'hF) && (pc != pc_last_reg);
      pend_v_eff  = pc_event || pend_pc_v_reg;
      pend_pc_eff = pc_event ? pc : pend_pc_reg;
`ifdef TRACE_WRITES_EN
      wr_event = cpu_run && io_wr && !io_wr_last_reg && (io_a[23:20] != 4'hF);
      enq_data = wr_event ? {1'b1, 4'b0000, io_a, io_di, 2'b10, io_be}
                          : {1'b0, 36'd0, pend_pc_eff, 6'b000000};
`else
      wr_event = 1'b0;
      enq_data = pend_pc_eff;
`endif
      enq            = wr_event || pend_v_eff;
      pend_pc_v_next = wr_event && pend_v_eff;
      pend_pc_next   = pend_pc_eff;
   end

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign room = (count_reg != FULL_COUNT) || pop;
   assign push = enq && room;

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_last_reg   <= '0;
         pend_pc_v_reg <= 1'b0;
         pend_pc_reg   <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         drop_cnt_reg  <= '0;
      end else begin
         pc_last_reg   <= pc;
         pend_pc_v_reg <= pend_pc_v_next;
         pend_pc_reg   <= pend_pc_next;
         count_reg     <= count_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (enq && !room && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
         end
      end
   end

`ifdef TRACE_WRITES_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         io_wr_last_reg <= 1'b0;
      end else begin
         io_wr_last_reg <= io_wr;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= enq_data;
      end
   end

   // Serializer: IDLE pops the head (1 cycle), SEND holds each symbol HOLD_CYCLES.
   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      pop        = 1'b0;
      shift      = 1'b0;
      test       = {2'b00, sr_reg[65:60]};
      case (state_reg)
         S_IDLE: begin
            if (count_reg != '0) begin
               pop        = 1'b1;
               hold_next  = '0;
               state_next = S_SEND;
            end
         end
         S_SEND: begin
            test = {(hold_reg >= HOLD_HALF), (k_reg == K_LAST), sr_reg[65:60]};
            if (hold_reg == HOLD_LAST) begin
               hold_next = '0;
               if (k_reg == K_LAST) begin
                  state_next = S_IDLE;
               end else begin
                  shift = 1'b1;
               end
            end else begin
               hold_next = hold_reg + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // The FIFO head is read straight into the shift register on pop;
   // P records are left-aligned so the symbol index starts at 6.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         hold_reg  <= '0;
         k_reg     <= '0;
         sr_reg    <= '0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         if (pop) begin
`ifdef TRACE_WRITES_EN
            if (mem[rd_ptr_reg][66]) begin
               sr_reg <= mem[rd_ptr_reg][65:0];
               k_reg  <= 4'd0;
            end else begin
               sr_reg <= {mem[rd_ptr_reg][29:0], 36'd0};
               k_reg  <= 4'd6;
            end
`else
            sr_reg <= {mem[rd_ptr_reg], 42'd0};
            k_reg  <= 4'd6;
`endif
         end else if (shift) begin
            sr_reg <= {sr_reg[59:0], 6'd0};
            k_reg  <= k_reg + 1'b1;
         end
      end
   end

   assign fifo_full = (count_reg == FULL_COUNT);
   assign drop_cnt  = drop_cnt_reg;

endmodule
